// File: rtl/cpri_rx_framer.sv
// cpri_rx_framer: aligns raw CPRI IQ words into SEQ_LEN-word blocks with gap/resync handling
module cpri_rx_framer #(
  parameter int SEQ_LEN = 96,
  parameter int DW      = 64,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [DW-1:0]    i_rx_data,
  input  logic             i_rx_vld,
  input  logic             i_resync,
  output logic [DW-1:0]    o_rx_data,
  output logic [6:0]       o_rx_seq,
  output logic             o_rx_vld,
  output logic             o_blk_last,
  output logic [CNT_W-1:0] o_blk_cnt,
  output logic             o_err_gap,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [1:0]       o_state
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [6:0] LAST = 7'(SEQ_LEN - 1);
  logic [1:0] state;
  logic [6:0] sc;
  logic [6:0] idx;
  logic       take;
  logic       at_last;
  logic       gap;
  // A word arriving in IDLE always starts a fresh block at index 0
  always_comb begin
    idx     = (state == RUN) ? sc : 7'd0;
    take    = i_rx_vld && !i_resync;
    at_last = idx == LAST;
    gap     = !i_resync && !i_rx_vld && state == RUN && sc != 7'd0;
  end
  assign o_state = state;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state      <= IDLE;
      sc         <= 7'd0;
      o_rx_data  <= '0;
      o_rx_seq   <= 7'd0;
      o_rx_vld   <= 1'b0;
      o_blk_last <= 1'b0;
      o_blk_cnt  <= '0;
      o_err_gap  <= 1'b0;
      o_err_cnt  <= '0;
    end else begin
      state      <= take ? RUN : IDLE;
      sc         <= (take && !at_last) ? idx + 7'd1 : 7'd0;
      o_rx_vld   <= take;
      o_rx_seq   <= take ? idx : 7'd0;
      o_blk_last <= take && at_last;
      o_err_gap  <= gap;
      if (take) o_rx_data <= i_rx_data;
      if (take && at_last && o_blk_cnt != '1) o_blk_cnt <= o_blk_cnt + CNT_W'(1);
      if (gap && o_err_cnt != '1) o_err_cnt <= o_err_cnt + CNT_W'(1);
    end
endmodule

// File: doc/cpri_rx_framer.md
CPRI_RX_FRAMER -- requirements
Module: cpri_rx_framer

Interface
REQ-001 Parameter SEQ_LEN, default 96: words per CPRI IQ block.
REQ-002 Parameter DW, default 64: data width.
REQ-003 Parameter CNT_W, default 16: status counter width.
REQ-004 Port i_clk, input, 1: single clock; all logic SHALL run on its rising edge.
REQ-005 Port i_reset, input, 1: asynchronous, active-high reset.
REQ-006 Port i_rx_data, input, DW: raw IQ word from the CPRI receive path.
REQ-007 Port i_rx_vld, input, 1: i_rx_data is valid this cycle.
REQ-008 Port i_resync, input, 1: synchronous pulse that forces block realignment.
REQ-009 Port o_rx_data, output, DW: registered copy of i_rx_data, sent to cpri_rxdata_unpack.
REQ-010 Port o_rx_seq, output, 7: word index within the block, 0..SEQ_LEN-1.
REQ-011 Port o_rx_vld, output, 1: o_rx_data and o_rx_seq are valid.
REQ-012 Port o_blk_last, output, 1: pulses with the word at seq SEQ_LEN-1.
REQ-013 Port o_blk_cnt, output, CNT_W: count of completed blocks, saturating.
REQ-014 Port o_err_gap, output, 1: one-cycle pulse when a block is truncated.
REQ-015 Port o_err_cnt, output, CNT_W: count of truncated blocks, saturating.
REQ-016 Port o_state, output, 2: FSM state encoding, IDLE=0, RUN=1.

Function
REQ-017 All outputs SHALL be registered, with exactly 1 cycle latency from input to output.
REQ-018 FSM states:
- IDLE: no block in progress.
- RUN: block in progress; internal seq counter sc holds the index of the next word.
REQ-019 IDLE with i_rx_vld=1 and i_resync=0:
- o_rx_vld=1, o_rx_seq=0, o_rx_data=i_rx_data.
- next state RUN with sc=1.
REQ-020 RUN with i_rx_vld=1:
- o_rx_vld=1, o_rx_seq=sc.
- if sc=SEQ_LEN-1: o_blk_last=1, o_blk_cnt increments, sc wraps to 0, state stays RUN.
- otherwise sc increments.
REQ-021 RUN with i_rx_vld=0 and sc=0 (block boundary):
- state goes to IDLE, o_rx_vld=0, no error.
REQ-022 RUN with i_rx_vld=0 and sc!=0 (mid-block gap):
- o_err_gap=1 for one cycle, o_err_cnt increments, state goes to IDLE, o_rx_vld=0.
- the next valid word restarts at seq 0.
REQ-023 i_resync=1 has priority in any state:
- next state IDLE, sc=0, o_rx_vld=0, and the word in that cycle is discarded.
- no error pulse and no block count.
REQ-024 o_blk_cnt and o_err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 When o_rx_vld=0, o_rx_data SHALL hold its last value, o_rx_seq SHALL be 0, and o_blk_last SHALL be 0.
REQ-026 o_blk_last and o_err_gap SHALL never assert in the same cycle.

Reset
REQ-027 While i_reset=1, all outputs SHALL be 0 immediately (asynchronous): o_rx_data=0, o_rx_seq=0, o_rx_vld=0, o_blk_last=0, o_blk_cnt=0, o_err_gap=0, o_err_cnt=0, and state IDLE.
REQ-028 Reset asserted mid-block SHALL abandon the block without an error count.
REQ-029 The first valid word after reset release SHALL be seq 0.

Verification
REQ-030 Continuous-block check:
- stimulus: i_rx_vld=1 for 192 cycles, data = cycle index.
- response: o_rx_seq runs 0..95 twice, o_blk_last at output cycles 96 and 192, o_blk_cnt=2, o_err_cnt=0, data delayed by 1.
REQ-031 Mid-block gap check:
- stimulus: 40 valid words, 1 idle cycle, then 96 valid words.
- response: one o_err_gap pulse, o_err_cnt=1, second burst seq 0..95, o_blk_cnt=1.
REQ-032 Boundary gap check:
- stimulus: 96 valid words, 5 idle cycles, 96 valid words.
- response: o_err_cnt=0, o_blk_cnt=2, state returns to 0 during the gap.
REQ-033 Resync check:
- stimulus: i_resync pulsed with valid at word 50 of a continuous stream.
- response: that word is dropped (o_rx_vld=0 one cycle), the next word is seq 0, o_err_cnt=0.
REQ-034 Async reset check:
- stimulus: i_reset asserted between clock edges at seq 30.
- response: outputs go to 0 before the next edge, and the restart after release is seq 0.
REQ-035 Saturation check:
- stimulus: CNT_W=4, 20 truncated blocks.
- response: o_err_cnt holds at 15.
